// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch stage. Walks sequential word addresses from START_ADDR,
// issues them to instruction memory with a one-cycle request/response
// protocol, and queues the returned instructions (with their PCs) in a small
// FIFO that feeds decode through a valid/ready handshake. A redirect pulse
// throws away everything queued or in flight and restarts fetch at a new
// word-aligned address.
//
// Ports:
//   clock        - single rising-edge clock
//   reset        - asynchronous active-high reset
//   stall        - inhibits issue of new memory requests
//   redirect     - one-cycle pulse: flush and resume at redirect_pc
//   redirect_pc  - new fetch address (low bits ignored for alignment)
//   pc           - registered memory address
//   rw           - registered read strobe, constant 1
//   access_size  - registered bytes per access, constant WORD_SIZE
//   enable       - registered memory request valid
//   mem_rdata    - read data, valid the cycle after an accepted request
//   inst         - instruction at the FIFO head
//   inst_pc      - address of inst
//   inst_valid   - FIFO non-empty
//   dec_ready    - decode accepts inst this cycle
// ---------------------------------------------------------------------------
module fetch_unit #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] START_ADDR = 32'h8002_0000,
    parameter int unsigned WORD_SIZE  = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  redirect,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  rw,
    output logic [31:0]           access_size,
    output logic                  enable,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    output logic                  inst_valid,
    input  logic                  dec_ready
);

    localparam int unsigned PTR_W      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned ALIGN_BITS = (WORD_SIZE > 1) ? $clog2(WORD_SIZE) : 0;

    localparam logic [ADDR_WIDTH-1:0] WORD_STEP  = ADDR_WIDTH'(WORD_SIZE);
    // Clears the byte-offset bits so a redirect always lands on a word boundary.
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);
    localparam logic [PTR_W-1:0]      LAST_SLOT  = PTR_W'(FIFO_DEPTH - 1);

    // Fetch-side state
    logic [ADDR_WIDTH-1:0] pc_next;
    logic                  enable_next;
    logic                  resp_pending;
    logic                  resp_pending_next;
    logic [ADDR_WIDTH-1:0] resp_pc;
    logic [ADDR_WIDTH-1:0] resp_pc_next;

    // Instruction queue
    logic [DATA_WIDTH-1:0] fifo_inst [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      wr_ptr;
    logic [CNT_W-1:0]      count;

    logic                  flush;
    logic                  push;
    logic                  pop;
    logic [31:0]           reserved;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_SLOT) ? '0 : p + 1'b1;
    endfunction

    // Queue handshake. A redirect suppresses both the pop and the push of
    // the response that was due, so nothing from the old stream survives.
    always_comb begin
        flush = redirect;
        pop   = 1'b0;
        push  = 1'b0;
        if (!redirect) begin
            pop  = inst_valid && dec_ready;
            push = resp_pending;
        end
    end

    // Slots the queue would need if another request went out next cycle:
    // what remains after this cycle's push/pop, plus the response still owed
    // for the request on the bus now, plus the new one. Issuing only when
    // this fits guarantees no response ever arrives to a full queue.
    always_comb begin
        reserved = 32'(count) - 32'(pop) + 32'(push) + 32'(enable) + 32'd1;
    end

    // Next-state for address generation and the response tracker.
    always_comb begin
        pc_next           = pc;
        enable_next       = 1'b0;
        resp_pending_next = 1'b0;
        resp_pc_next      = resp_pc;
        if (redirect) begin
            // The request being sampled right now is abandoned by forcing
            // resp_pending low; its data will simply be ignored next cycle.
            pc_next           = redirect_pc & ALIGN_MASK;
            enable_next       = !stall;
            resp_pending_next = 1'b0;
            resp_pc_next      = pc;
        end else begin
            resp_pending_next = enable;
            resp_pc_next      = pc;
            pc_next           = enable ? (pc + WORD_STEP) : pc;
            enable_next       = !stall && (reserved <= 32'(FIFO_DEPTH));
        end
    end

    // Memory-facing registers. rw and access_size never change after reset
    // but are kept registered so every memory-side output comes from a flop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc           <= START_ADDR;
            enable       <= 1'b0;
            rw           <= 1'b1;
            access_size  <= 32'(WORD_SIZE);
            resp_pending <= 1'b0;
            resp_pc      <= START_ADDR;
        end else begin
            pc           <= pc_next;
            enable       <= enable_next;
            rw           <= 1'b1;
            access_size  <= 32'(WORD_SIZE);
            resp_pending <= resp_pending_next;
            resp_pc      <= resp_pc_next;
        end
    end

    // Queue storage holds no control meaning, so it is left out of reset;
    // validity is tracked entirely by count and the pointers.
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_inst[wr_ptr] <= mem_rdata;
            fifo_pc[wr_ptr]   <= resp_pc;
        end
    end

    // Queue pointers and occupancy. Push and pop in the same cycle leave the
    // count unchanged, including when the queue is full or empty.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Decode-side view of the queue head.
    always_comb begin
        inst       = fifo_inst[rd_ptr];
        inst_pc    = fifo_pc[rd_ptr];
        inst_valid = (count != '0);
    end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. A behavioural instruction memory answers
// every accepted request one cycle later with a word derived from its
// address. Expected fetch PCs are loaded into a scoreboard queue whenever the
// stimulus starts a new stream (reset release or redirect), and each decode
// handshake pops the queue and compares PC and instruction.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] START = 32'h8002_0000;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] pc;
    logic        rw;
    logic [31:0] access_size;
    logic        enable;
    logic [31:0] mem_rdata;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        dec_ready;

    int          errors   = 0;
    int          checks   = 0;
    int          hs_count = 0;
    logic [31:0] sb_q [$];

    fetch_unit dut (
        .clock       (clock),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .pc          (pc),
        .rw          (rw),
        .access_size (access_size),
        .enable      (enable),
        .mem_rdata   (mem_rdata),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid),
        .dec_ready   (dec_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // Instruction memory: samples pc/enable at the edge, data valid next cycle.
    always @(posedge clock) begin
        mem_rdata <= enable ? mem_word(pc) : 32'hDEAD_BEEF;
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic load_expected(input logic [31:0] start_pc);
        sb_q.delete();
        for (int i = 0; i < 200; i++) begin
            sb_q.push_back(start_pc + 32'(4 * i));
        end
    endtask

    task automatic apply_stimulus(input logic s, input logic r);
        stall     = s;
        dec_ready = r;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Inputs change just after the rising edge, so the values seen at the
    // falling edge are the ones the next rising edge will act on.
    always @(negedge clock) begin
        if (!reset && !redirect && inst_valid && dec_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $error("[TB] FAIL sb_empty observed=%h expected=none", inst_pc);
            end else begin
                logic [31:0] exp_pc;
                exp_pc = sb_q.pop_front();
                check_output("inst_pc", inst_pc, exp_pc);
                check_output("inst", inst, mem_word(exp_pc));
                hs_count++;
            end
        end
    end

    initial begin
        int          base;
        logic [31:0] exp_head;

        reset       = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        apply_stimulus(1'b0, 1'b1);

        // Reset values
        repeat (3) step();
        check_output("rst_pc", pc, START);
        check_output("rst_enable", 32'(enable), 32'd0);
        check_output("rst_rw", 32'(rw), 32'd1);
        check_output("rst_access_size", access_size, 32'd4);
        check_output("rst_inst_valid", 32'(inst_valid), 32'd0);

        // Start-up latency and steady streaming
        load_expected(START);
        reset = 1'b0;
        step();
        check_output("start_enable", 32'(enable), 32'd1);
        check_output("start_pc", pc, START);
        step();
        check_output("start_valid_early", 32'(inst_valid), 32'd0);
        step();
        check_output("start_valid", 32'(inst_valid), 32'd1);
        for (int i = 0; i < 6; i++) begin
            step();
            check_output("steady_valid", 32'(inst_valid), 32'd1);
        end

        // Decode backpressure fills the queue, then drain with issue stalled
        apply_stimulus(1'b0, 1'b0);
        repeat (10) step();
        check_output("bp_enable", 32'(enable), 32'd0);
        check_output("bp_valid", 32'(inst_valid), 32'd1);
        check_output("bp_head_pc", inst_pc, sb_q[0]);
        apply_stimulus(1'b1, 1'b1);
        base = hs_count;
        repeat (6) step();
        check_output("bp_drain_count", 32'(hs_count - base), 32'd4);
        check_output("bp_drained_valid", 32'(inst_valid), 32'd0);
        apply_stimulus(1'b0, 1'b1);
        repeat (8) step();

        // Stall for three edges mid-stream
        exp_head = sb_q[0];
        apply_stimulus(1'b1, 1'b1);
        step();
        check_output("stall_enable", 32'(enable), 32'd0);
        check_output("stall_pc", pc, exp_head + 32'd12);
        repeat (2) step();
        apply_stimulus(1'b0, 1'b1);
        step();
        check_output("stall_resume_enable", 32'(enable), 32'd1);
        check_output("stall_resume_pc", pc, exp_head + 32'd12);
        repeat (6) step();

        // Redirect with responses in flight, unaligned target
        redirect    = 1'b1;
        redirect_pc = 32'h8002_0102;
        load_expected(32'h8002_0100);
        step();
        redirect = 1'b0;
        check_output("redir_valid", 32'(inst_valid), 32'd0);
        check_output("redir_pc", pc, 32'h8002_0100);
        base = hs_count;
        repeat (6) step();
        check_output("redir_hs_count", 32'(hs_count - base), 32'd4);

        // Redirect near the top of the address space to exercise wrap
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        load_expected(32'hFFFF_FFF8);
        step();
        redirect = 1'b0;
        base = hs_count;
        repeat (6) step();
        check_output("wrap_hs_count", 32'(hs_count - base), 32'd4);

        // Asynchronous reset while busy
        apply_stimulus(1'b0, 1'b0);
        step();
        check_output("pre_reset_enable", 32'(enable), 32'd1);
        reset = 1'b1;
        #1;
        check_output("async_rst_pc", pc, START);
        check_output("async_rst_enable", 32'(enable), 32'd0);
        check_output("async_rst_valid", 32'(inst_valid), 32'd0);
        check_output("async_rst_rw", 32'(rw), 32'd1);
        check_output("async_rst_access_size", access_size, 32'd4);
        load_expected(START);
        apply_stimulus(1'b0, 1'b1);
        repeat (2) step();
        reset = 1'b0;
        base = hs_count;
        repeat (8) step();
        check_output("restart_hs_count", 32'(hs_count - base), 32'd5);

        $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
